lag_source_fifo_router: RTL and testbench

Injection-side flit buffer with head-flit route computation, placed between a traffic source and a router input port. Flits are queued in a first-word-visible FIFO. The flit at the FIFO head is presented on the output; if it is a head flit, its output-port field is filled in using XY dimension-ordered routing on the destination displacement it carries. Body and tail flits pass through unchanged.

---
 rtl/lag_source_fifo_router.sv | 93 +++++++++
 tb/tb_lag_source_fifo_router.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lag_source_fifo_router.sv
// Injection-side flit FIFO with XY route computation on the head entry.
// The FIFO is first-word-visible. The routed view of the head entry is
// purely combinational, so it adds no latency.
module lag_source_fifo_router #(
  parameter int size         = 14,
  parameter int data_width   = 16,
  parameter int router_radix = 5,
  parameter int x_addr_bits  = 2,
  parameter int y_addr_bits  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [data_width+2:0] data_in,
  output logic [data_width+2:0] data_out,
  output logic [data_width+2:0] flit_out,
  output logic                  empty,
  output logic                  full,
  output logic                  nearly_empty,
  output logic                  nearly_full,
  output logic                  out_valid
);
  localparam int FW = data_width + 3;
  localparam int PW = (size > 1) ? $clog2(size) : 1;
  localparam int CW = $clog2(size + 1);
  localparam int XL = router_radix;
  localparam int XH = router_radix + x_addr_bits;
  localparam int YL = router_radix + x_addr_bits + 1;
  localparam int YH = router_radix + x_addr_bits + y_addr_bits + 1;
  localparam int HEAD_BIT = data_width + 1;

  logic [FW-1:0] r_mem [size];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;

  logic w_push_ok, w_pop_ok;
  logic signed [x_addr_bits:0] w_x;
  logic signed [y_addr_bits:0] w_y;
  logic [router_radix-1:0]     w_port;

  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  // Pointers, occupancy count and storage. Memory is cleared so data_out is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < size; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= data_in;
        r_wr        <= (r_wr == PW'(size - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop_ok)
        r_rd <= (r_rd == PW'(size - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign data_out     = r_mem[r_rd];
  assign empty        = (r_cnt == '0);
  assign full         = (r_cnt == CW'(size));
  assign nearly_empty = (r_cnt <= CW'(1));
  assign nearly_full  = (r_cnt >= CW'(size - 1));
  assign out_valid    = !empty;

  assign w_x = data_out[XH:XL];
  assign w_y = data_out[YH:YL];

  // XY dimension-ordered route: resolve X first, then Y, otherwise eject locally.
  always_comb begin
    w_port = '0;
    if (w_x > 0)       w_port[1] = 1'b1;
    else if (w_x < 0)  w_port[3] = 1'b1;
    else if (w_y > 0)  w_port[0] = 1'b1;
    else if (w_y < 0)  w_port[2] = 1'b1;
    else               w_port[router_radix-1] = 1'b1;
  end

  // Only head flits carry a destination; body and tail flits pass unchanged.
  always_comb begin
    flit_out = data_out;
    if (data_out[HEAD_BIT]) flit_out[router_radix-1:0] = w_port;
  end
endmodule

// File: tb/tb_lag_source_fifo_router.sv
// Directed bench for lag_source_fifo_router with default parameters.
module tb_lag_source_fifo_router;
  localparam int FW = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop;
  logic [FW-1:0] data_in;
  logic [FW-1:0] data_out, flit_out;
  logic          empty, full, nearly_empty, nearly_full, out_valid;

  int checks = 0;
  int failures = 0;

  lag_source_fifo_router dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .flit_out(flit_out), .empty(empty), .full(full),
    .nearly_empty(nearly_empty), .nearly_full(nearly_full), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic v, input logic h, input logic t,
                                       input logic [15:0] d);
    return {v, h, t, d};
  endfunction

  // One clock: drive push/pop/data, let the edge happen, sample 1 time unit later.
  task automatic cyc(input logic p, input logic q, input logic [FW-1:0] d);
    push = p; pop = q; data_in = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; data_in = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    #3;
    checks++; if (empty !== 1'b1)        begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)         begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (nearly_empty !== 1'b1) begin failures++; $display("FAIL rst_nempty got=%b exp=1", nearly_empty); end
    checks++; if (nearly_full !== 1'b0)  begin failures++; $display("FAIL rst_nfull got=%b exp=0", nearly_full); end
    checks++; if (out_valid !== 1'b0)    begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (flit_out !== '0)       begin failures++; $display("FAIL rst_flit_out got=%h exp=0", flit_out); end
    checks++; if (data_out !== '0)       begin failures++; $display("FAIL rst_data_out got=%h exp=0", data_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, '0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL idle_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 14; i++) begin
      cyc(1, 0, mk(1, 0, 0, 16'(i)));
      if (i == 12) begin
        checks++; if (nearly_full !== 1'b0) begin failures++; $display("FAIL fill12_nfull got=%b exp=0", nearly_full); end
      end
      if (i == 13) begin
        checks++; if (nearly_full !== 1'b1) begin failures++; $display("FAIL fill13_nfull got=%b exp=1", nearly_full); end
        checks++; if (full !== 1'b0)        begin failures++; $display("FAIL fill13_full got=%b exp=0", full); end
      end
      if (i == 1) begin
        checks++; if (data_out !== mk(1, 0, 0, 16'd1)) begin failures++; $display("FAIL push_latency got=%h exp=%h", data_out, mk(1, 0, 0, 16'd1)); end
      end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill14_full got=%b exp=1", full); end
    cyc(1, 0, mk(1, 0, 0, 16'hFF));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL overflow_full got=%b exp=1", full); end
    for (int i = 1; i <= 14; i++) begin
      checks++;
      if (data_out !== mk(1, 0, 0, 16'(i))) begin
        failures++; $display("FAIL drain_%0d got=%h exp=%h", i, data_out, mk(1, 0, 0, 16'(i)));
      end
      cyc(0, 1, '0);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    cyc(0, 1, '0);
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL underflow got=%b%b exp=10", empty, full); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 1; i <= 14; i++) cyc(1, 0, mk(1, 0, 0, 16'(i)));
    cyc(1, 1, mk(1, 0, 0, 16'hAA));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fullpp_full got=%b exp=1", full); end
    for (int i = 2; i <= 15; i++) begin
      logic [FW-1:0] e;
      e = (i == 15) ? mk(1, 0, 0, 16'hAA) : mk(1, 0, 0, 16'(i));
      checks++;
      if (data_out !== e) begin failures++; $display("FAIL fullpp_drain_%0d got=%h exp=%h", i, data_out, e); end
      cyc(0, 1, '0);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fullpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_push_pop;
    cyc(1, 1, mk(1, 0, 0, 16'h55));
    checks++; if (data_out !== mk(1, 0, 0, 16'h55)) begin failures++; $display("FAIL emptypp_data got=%h exp=%h", data_out, mk(1, 0, 0, 16'h55)); end
    checks++; if (empty !== 1'b0 || nearly_empty !== 1'b1 || out_valid !== 1'b1)
      begin failures++; $display("FAIL emptypp_flags got=%b%b%b exp=011", empty, nearly_empty, out_valid); end
    cyc(0, 1, '0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL emptypp_pop got=%b exp=1", empty); end
  endtask

  task automatic route_case(input string nm, input logic [2:0] x, input logic [2:0] y,
                            input logic [4:0] port);
    logic [15:0] d, e;
    d = {5'b10100, y, x, 5'b11111};
    e = {5'b10100, y, x, port};
    cyc(1, 0, mk(1, 1, 0, d));
    checks++;
    if (flit_out !== mk(1, 1, 0, e)) begin
      failures++; $display("FAIL route_%s got=%h exp=%h", nm, flit_out, mk(1, 1, 0, e));
    end
    cyc(0, 1, '0);
  endtask

  task automatic test_route;
    route_case("east",  3'sd2,  -3'sd1, 5'b00010);
    route_case("west",  -3'sd1, 3'sd3,  5'b01000);
    route_case("north", 3'sd0,  3'sd1,  5'b00001);
    route_case("south", 3'sd0,  -3'sd2, 5'b00100);
    route_case("local", 3'sd0,  3'sd0,  5'b10000);
  endtask

  task automatic test_body_tail;
    logic [FW-1:0] b, t;
    b = mk(1, 0, 0, {5'b0, 3'd1, 3'd1, 5'b10101});
    t = mk(1, 0, 1, {5'b0, 3'd2, 3'd0, 5'b01010});
    cyc(1, 0, b);
    checks++; if (flit_out !== b) begin failures++; $display("FAIL body_pass got=%h exp=%h", flit_out, b); end
    cyc(1, 1, t);
    checks++; if (flit_out !== t) begin failures++; $display("FAIL tail_pass got=%h exp=%h", flit_out, t); end
    cyc(0, 1, '0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) cyc(1, 0, mk(1, 0, 0, 16'(i + 7)));
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL mid_pre_empty got=%b exp=0", empty); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || data_out !== '0)
      begin failures++; $display("FAIL mid_reset got empty=%b data=%h exp empty=1 data=0", empty, data_out); end
    #3 rst_n = 1'b1;
    cyc(0, 0, '0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_post_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_full_push_pop;
    test_empty_push_pop;
    test_route;
    test_body_tail;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
